// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage access unit and data memory.
// The unit drives the registered request side; memory returns read data and ack.
interface mem_access_unit_if;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_we_out;
  logic        dmem_req_out;
  logic [31:0] dmem_rdata_in;
  logic        dmem_ack_in;

  modport master (
    output dmem_addr_out, dmem_wdata_out, dmem_be_out, dmem_we_out, dmem_req_out,
    input  dmem_rdata_in, dmem_ack_in
  );

  modport slave (
    input  dmem_addr_out, dmem_wdata_out, dmem_be_out, dmem_we_out, dmem_req_out,
    output dmem_rdata_in, dmem_ack_in
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: aligns load/store requests, runs a req/ack
// handshake with optional timeout, stalls the pipeline and extends load results.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mem_read_in,
  input  logic [2:0]        mem_write_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       store_data_in,
  mem_access_unit_if.master dmem,
  output logic [31:0]       load_data_out,
  output logic              stall_out,
  output logic              misaligned_out,
  output logic              bus_error_out
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [1:0]    off_q;
  logic [2:0]    funct3_q;

  logic          access, is_store, mis;
  logic [1:0]    size;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic          start, ack_done, to_done, timeout_hit;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ext_data;

  // size: 0 = byte, 1 = half, 2 = word; store wins when both enables are set
  always_comb begin
    access   = mem_read_in[3] | mem_write_in[2];
    is_store = mem_write_in[2];
    size     = 2'd2;
    if (is_store) begin
      size = (mem_write_in[1:0] == 2'b11) ? 2'd2 : mem_write_in[1:0];
    end else begin
      case (mem_read_in[1:0])
        2'b00:   size = 2'd0;
        2'b01:   size = 2'd1;
        default: size = 2'd2;
      endcase
    end
    mis = access & (((size == 2'd1) & addr_in[0]) | ((size == 2'd2) & (addr_in[1:0] != 2'b00)));
    case (size)
      2'd0:    be_c = 4'b0001 << addr_in[1:0];
      2'd1:    be_c = 4'b0011 << addr_in[1:0];
      default: be_c = 4'b1111;
    endcase
    wdata_c = '0;
    if (is_store) begin
      case (size)
        2'd0:    wdata_c = {4{store_data_in[7:0]}};
        2'd1:    wdata_c = {2{store_data_in[15:0]}};
        default: wdata_c = store_data_in;
      endcase
    end
  end

  assign misaligned_out = mis;
  assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (count == LAST);

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = dmem.dmem_rdata_in[7:0];
      2'd1:    byte_sel = dmem.dmem_rdata_in[15:8];
      2'd2:    byte_sel = dmem.dmem_rdata_in[23:16];
      default: byte_sel = dmem.dmem_rdata_in[31:24];
    endcase
    half_sel = off_q[1] ? dmem.dmem_rdata_in[31:16] : dmem.dmem_rdata_in[15:0];
    case (funct3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {24'b0, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'b0, half_sel};
      default: ext_data = dmem.dmem_rdata_in;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    start      = 1'b0;
    ack_done   = 1'b0;
    to_done    = 1'b0;
    case (state)
      IDLE: begin
        if (access && !mis) begin
          stall_out  = 1'b1;
          start      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        stall_out = 1'b1;
        if (dmem.dmem_ack_in) begin
          ack_done   = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          to_done    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The byte offset and funct3 are kept internally because dmem_addr_out is word-aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.dmem_addr_out  <= '0;
      dmem.dmem_wdata_out <= '0;
      dmem.dmem_be_out    <= '0;
      dmem.dmem_we_out    <= 1'b0;
      dmem.dmem_req_out   <= 1'b0;
      load_data_out       <= '0;
      bus_error_out       <= 1'b0;
      count               <= '0;
      off_q               <= '0;
      funct3_q            <= '0;
    end else begin
      if (start) begin
        dmem.dmem_addr_out  <= {addr_in[31:2], 2'b00};
        dmem.dmem_wdata_out <= wdata_c;
        dmem.dmem_be_out    <= be_c;
        dmem.dmem_we_out    <= is_store;
        dmem.dmem_req_out   <= 1'b1;
        count               <= '0;
        off_q               <= addr_in[1:0];
        funct3_q            <= mem_read_in[2:0];
      end
      if (ack_done) begin
        dmem.dmem_req_out <= 1'b0;
        if (!dmem.dmem_we_out) load_data_out <= ext_data;
      end else if (to_done) begin
        dmem.dmem_req_out <= 1'b0;
        if (!dmem.dmem_we_out) load_data_out <= '0;
        bus_error_out <= 1'b1;
      end else if (state == WAIT) begin
        if (count != '1) count <= count + 1'b1;
      end
      if (state == DONE) bus_error_out <= 1'b0;
    end
  end

endmodule
